jtag_scan_master: RTL

- Clocked JTAG host engine that drives a TAP (TCK/TMS/TDI, samples TDO) from simple commands: TAP reset, IR scan and DR scan.
- Generates TCK as a divided `clk`, walks the TAP state machine with fixed TMS sequences, shifts data LSB-first and returns the captured TDO bits.
- Sits between on-board control logic (tumblers/BIST sequencer) and the TAP/IR/DR/BSR chain, so scans run in simulation and on the board without an external probe.

---
 rtl/jtag_scan_master_if.sv | 24 ++
 rtl/jtag_scan_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master_if.sv
// rtl/jtag_scan_master_if.sv - command/response handshake bundle between a requester and the JTAG scan master
interface jtag_scan_master_if #(
    parameter int DR_MAX = 32,
    parameter int CNT_W  = $clog2(DR_MAX + 1)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [CNT_W-1:0]  cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_type, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG host engine: TAP reset, IR and DR scans over a divided TCK
module jtag_scan_master #(
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 32,
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = $clog2(DR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    jtag_scan_master_if.slave bus,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DR_MAX);

    typedef enum logic [2:0] {S_IDLE, S_RST_SEQ, S_HDR, S_SHIFT, S_TRAIL, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_idx;
    logic [DIV_W-1:0]  r_div;
    logic [DR_MAX-1:0] r_data;
    logic [DR_MAX-1:0] r_cap;
    logic [DR_MAX-1:0] r_rsp_data;
    logic [CNT_W-1:0]  r_len;
    logic              r_is_ir;
    logic              r_is_scan;
    logic              r_tap_known;
    logic              r_tck;
    logic              r_tms;
    logic              r_tdi;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_busy;

    state_t            w_nstate;
    logic [CNT_W-1:0]  w_nidx;
    logic [CNT_W-1:0]  w_shift_n;
    logic              w_ntms;
    logic              w_ntdi;
    logic              w_cmd_scan;
    logic              w_cmd_zero;
    logic [CNT_W-1:0]  w_cmd_len;

    assign w_cmd_scan = (bus.cmd_type == 2'b01) || (bus.cmd_type == 2'b10);
    assign w_cmd_zero = (bus.cmd_type == 2'b10) && (bus.cmd_len == '0);
    assign w_cmd_len  = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

    // Position and pin values of the bit-cycle that follows the current one.
    always_comb begin
        w_shift_n = r_is_ir ? CNT_W'(IR_LEN) : r_len;
        w_nstate  = r_state;
        w_nidx    = r_idx + CNT_W'(1);
        w_ntms    = 1'b0;
        w_ntdi    = 1'b0;
        case (r_state)
            S_RST_SEQ: if (r_idx == CNT_W'(5)) begin
                w_nstate = r_is_scan ? S_HDR : S_DONE;
                w_nidx   = '0;
            end
            S_HDR: if (r_idx == (r_is_ir ? CNT_W'(3) : CNT_W'(2))) begin
                w_nstate = S_SHIFT;
                w_nidx   = '0;
            end
            S_SHIFT: if (r_idx == w_shift_n - CNT_W'(1)) begin
                w_nstate = S_TRAIL;
                w_nidx   = '0;
            end
            S_TRAIL: if (r_idx == CNT_W'(1)) begin
                w_nstate = S_DONE;
                w_nidx   = '0;
            end
            default: begin
                w_nstate = S_IDLE;
                w_nidx   = '0;
            end
        endcase
        case (w_nstate)
            S_RST_SEQ: w_ntms = (w_nidx != CNT_W'(5));
            S_HDR:     w_ntms = r_is_ir ? (w_nidx < CNT_W'(2)) : (w_nidx == '0);
            S_SHIFT: begin
                w_ntms = (w_nidx == w_shift_n - CNT_W'(1));
                w_ntdi = |(r_data & (DR_MAX'(1) << w_nidx));
            end
            S_TRAIL:   w_ntms = (w_nidx == '0);
            default:   w_ntms = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_div       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_rsp_data  <= '0;
            r_len       <= '0;
            r_is_ir     <= 1'b0;
            r_is_scan   <= 1'b0;
            r_tap_known <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (bus.cmd_valid) begin
                        r_data    <= bus.cmd_data;
                        r_len     <= w_cmd_len;
                        r_is_ir   <= (bus.cmd_type == 2'b01);
                        r_is_scan <= w_cmd_scan;
                        r_cap     <= '0;
                        r_idx     <= '0;
                        r_div     <= '0;
                        r_tck     <= 1'b0;
                        r_tdi     <= 1'b0;
                        if (w_cmd_zero) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            // Both the reset walk and every scan header open with TMS=1.
                            r_state     <= (w_cmd_scan && r_tap_known) ? S_HDR : S_RST_SEQ;
                            r_tms       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            if (r_state == S_SHIFT) begin
                                r_cap <= r_cap | (DR_MAX'(TDO) << r_idx);
                            end
                        end else begin
                            r_tck   <= 1'b0;
                            r_state <= w_nstate;
                            r_idx   <= w_nidx;
                            r_tms   <= w_ntms;
                            r_tdi   <= w_ntdi;
                            if (r_state == S_RST_SEQ && w_nstate != S_RST_SEQ) begin
                                r_tap_known <= 1'b1;
                            end
                            if (w_nstate == S_DONE) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= r_cap;
                                r_busy      <= 1'b0;
                                r_cmd_ready <= 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign TCK           = r_tck;
    assign TMS           = r_tms;
    assign TDI           = r_tdi;
endmodule
